// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mips_pkg
// Brief   : Shared opcode/funct constants, FSM state and ALU-op encodings
// Revision: 1.0  initial release
// ============================================================================
package mips_pkg;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_SLT = 3'd4
    } alu_op_t;

    localparam logic [5:0] c_op_rtype = 6'h00;
    localparam logic [5:0] c_op_j     = 6'h02;
    localparam logic [5:0] c_op_beq   = 6'h04;
    localparam logic [5:0] c_op_addi  = 6'h08;
    localparam logic [5:0] c_op_lw    = 6'h23;
    localparam logic [5:0] c_op_sw    = 6'h2B;

    localparam logic [5:0] c_fn_syscall = 6'h0C;
    localparam logic [5:0] c_fn_add     = 6'h20;
    localparam logic [5:0] c_fn_sub     = 6'h22;
    localparam logic [5:0] c_fn_and     = 6'h24;
    localparam logic [5:0] c_fn_or      = 6'h25;
    localparam logic [5:0] c_fn_slt     = 6'h2A;

    function automatic logic [31:0] bswap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/mips_multicycle_core_if.sv
`default_nettype none
// ============================================================================
// Module  : mips_multicycle_core_if
// Brief   : Instruction and data memory request/ready bus of the core
// Revision: 1.0  initial release
// ============================================================================
interface mips_multicycle_core_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;

    modport master (
        output imem_req, imem_addr,
        input  imem_ready, imem_rdata,
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_ready, dmem_rdata
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ready, imem_rdata,
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_ready, dmem_rdata
    );

endinterface
`default_nettype wire

// File: rtl/mc_regfile.sv
`default_nettype none
// ============================================================================
// Module  : mc_regfile
// Brief   : 32x32 register file, two async reads, one sync write, $0 = 0
// Revision: 1.0  initial release
// ============================================================================
module mc_regfile (
    input  wire         clk,
    input  wire         rst_b,
    input  wire  [4:0]  i_raddr_a,
    input  wire  [4:0]  i_raddr_b,
    output logic [31:0] o_rdata_a,
    output logic [31:0] o_rdata_b,
    input  wire         i_we,
    input  wire  [4:0]  i_waddr,
    input  wire  [31:0] i_wdata
);

    logic [31:0] r_regs [32];

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_we && (i_waddr != 5'd0)) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_a = (i_raddr_a == 5'd0) ? 32'd0 : r_regs[i_raddr_a];
    assign o_rdata_b = (i_raddr_b == 5'd0) ? 32'd0 : r_regs[i_raddr_b];

endmodule
`default_nettype wire

// File: rtl/mips_multicycle_core.sv
`default_nettype none
// ============================================================================
// Module  : mips_multicycle_core
// Brief   : Multicycle MIPS subset core with request/ready memory ports
// Revision: 1.0  initial release
// ============================================================================
module mips_multicycle_core #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned MEM_TIMEOUT = 0,
    parameter bit          BIG_ENDIAN  = 1'b1
) (
    input  wire                     clk,
    input  wire                     rst_b,
    mips_multicycle_core_if.master  bus,
    output logic                    halted,
    output logic                    err
);
    import mips_pkg::*;

    localparam logic [31:0] c_timeout_last = MEM_TIMEOUT - 1;

    state_t      r_state;
    logic [31:0] r_pc, r_ir, r_a, r_b, r_alu_out, r_mdr;
    logic [31:0] r_dmem_addr, r_dmem_wdata, r_wait_cnt;
    logic        r_dmem_we, r_halted, r_err;

    logic [5:0]  w_op, w_funct;
    logic [4:0]  w_rs, w_rt, w_rd;
    logic [31:0] w_imm_sext, w_alu_b, w_alu_res, w_mem_addr, w_rf_a, w_rf_b;
    logic        w_legal, w_syscall, w_timeout;
    alu_op_t     w_alu_op;

    assign w_op       = r_ir[31:26];
    assign w_rs       = r_ir[25:21];
    assign w_rt       = r_ir[20:16];
    assign w_rd       = r_ir[15:11];
    assign w_funct    = r_ir[5:0];
    assign w_imm_sext = {{16{r_ir[15]}}, r_ir[15:0]};
    assign w_mem_addr = r_a + w_imm_sext;
    assign w_timeout  = (MEM_TIMEOUT != 0) && (r_wait_cnt == c_timeout_last);

    always_comb begin
        w_legal   = 1'b0;
        w_syscall = 1'b0;
        w_alu_op  = ALU_ADD;
        case (w_op)
            c_op_rtype: begin
                case (w_funct)
                    c_fn_add:     w_legal = 1'b1;
                    c_fn_sub:     begin w_legal = 1'b1; w_alu_op = ALU_SUB; end
                    c_fn_and:     begin w_legal = 1'b1; w_alu_op = ALU_AND; end
                    c_fn_or:      begin w_legal = 1'b1; w_alu_op = ALU_OR;  end
                    c_fn_slt:     begin w_legal = 1'b1; w_alu_op = ALU_SLT; end
                    c_fn_syscall: begin w_legal = 1'b1; w_syscall = 1'b1;   end
                    default:      w_legal = 1'b0;
                endcase
            end
            c_op_addi, c_op_lw, c_op_sw, c_op_beq, c_op_j: w_legal = 1'b1;
            default: w_legal = 1'b0;
        endcase
    end

    assign w_alu_b = (w_op == c_op_rtype) ? r_b : w_imm_sext;

    always_comb begin
        case (w_alu_op)
            ALU_SUB: w_alu_res = r_a - w_alu_b;
            ALU_AND: w_alu_res = r_a & w_alu_b;
            ALU_OR:  w_alu_res = r_a | w_alu_b;
            ALU_SLT: w_alu_res = {31'd0, $signed(r_a) < $signed(w_alu_b)};
            default: w_alu_res = r_a + w_alu_b;
        endcase
    end

    mc_regfile u_regfile (
        .clk       (clk),
        .rst_b     (rst_b),
        .i_raddr_a (w_rs),
        .i_raddr_b (w_rt),
        .o_rdata_a (w_rf_a),
        .o_rdata_b (w_rf_b),
        .i_we      (r_state == WB),
        .i_waddr   ((w_op == c_op_rtype) ? w_rd : w_rt),
        .i_wdata   ((w_op == c_op_lw) ? r_mdr : r_alu_out)
    );

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state      <= FETCH;
            r_pc         <= RESET_PC;
            r_ir         <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_alu_out    <= '0;
            r_mdr        <= '0;
            r_dmem_addr  <= '0;
            r_dmem_wdata <= '0;
            r_dmem_we    <= 1'b0;
            r_wait_cnt   <= '0;
            r_halted     <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            case (r_state)
                FETCH: begin
                    if (bus.imem_ready) begin
                        r_ir       <= bus.imem_rdata;
                        r_pc       <= r_pc + 32'd4;
                        r_wait_cnt <= '0;
                        r_state    <= DECODE;
                    end else if (w_timeout) begin
                        r_state  <= HALT;
                        r_halted <= 1'b1;
                        r_err    <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 32'd1;
                    end
                end
                DECODE: begin
                    if (!w_legal || w_syscall) begin
                        r_state  <= HALT;
                        r_halted <= 1'b1;
                        r_err    <= !w_legal;
                    end else begin
                        r_a     <= w_rf_a;
                        r_b     <= w_rf_b;
                        r_state <= EXEC;
                    end
                end
                EXEC: begin
                    case (w_op)
                        c_op_beq: begin
                            if (r_a == r_b) r_pc <= r_pc + {w_imm_sext[29:0], 2'b00};
                            r_state <= FETCH;
                        end
                        c_op_j: begin
                            r_pc    <= {r_pc[31:28], r_ir[25:0], 2'b00};
                            r_state <= FETCH;
                        end
                        c_op_lw, c_op_sw: begin
                            if (w_mem_addr[1:0] != 2'b00) begin
                                r_state  <= HALT;
                                r_halted <= 1'b1;
                                r_err    <= 1'b1;
                            end else begin
                                r_dmem_addr  <= w_mem_addr;
                                r_dmem_we    <= (w_op == c_op_sw);
                                r_dmem_wdata <= BIG_ENDIAN ? r_b : bswap32(r_b);
                                r_state      <= MEM;
                            end
                        end
                        default: begin
                            r_alu_out <= w_alu_res;
                            r_state   <= WB;
                        end
                    endcase
                end
                MEM: begin
                    if (bus.dmem_ready) begin
                        r_mdr      <= BIG_ENDIAN ? bus.dmem_rdata : bswap32(bus.dmem_rdata);
                        r_dmem_we  <= 1'b0;
                        r_wait_cnt <= '0;
                        r_state    <= r_dmem_we ? FETCH : WB;
                    end else if (w_timeout) begin
                        r_dmem_we <= 1'b0;
                        r_state   <= HALT;
                        r_halted  <= 1'b1;
                        r_err     <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 32'd1;
                    end
                end
                WB:      r_state <= FETCH;
                HALT:    r_state <= HALT;
                default: begin
                    r_state  <= HALT;
                    r_halted <= 1'b1;
                    r_err    <= 1'b1;
                end
            endcase
        end
    end

    // Requests follow the state directly so a fetch goes out in the very first
    // cycle after reset; rst_b gating keeps them low while reset is held.
    assign bus.imem_req   = rst_b && (r_state == FETCH);
    assign bus.imem_addr  = r_pc;
    assign bus.dmem_req   = rst_b && (r_state == MEM);
    assign bus.dmem_we    = r_dmem_we;
    assign bus.dmem_addr  = r_dmem_addr;
    assign bus.dmem_wdata = r_dmem_wdata;
    assign halted         = r_halted;
    assign err            = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mips_multicycle_core.sv
`default_nettype none
// ============================================================================
// Module  : tb_mips_multicycle_core
// Brief   : Directed self-checking bench for mips_multicycle_core
// Revision: 1.0  initial release
// ============================================================================
module tb_mips_multicycle_core;

    logic clk = 1'b0;
    logic rst_b = 1'b0;
    logic halted, err, halted_to, err_to;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   dlat    = 0;
    int   dcnt;
    int   n_dreq;

    logic [31:0] rom  [128];
    logic [31:0] dmem [64];

    mips_multicycle_core_if bus ();
    mips_multicycle_core_if bus_to ();

    always #5 clk = ~clk;

    mips_multicycle_core dut (
        .clk    (clk),
        .rst_b  (rst_b),
        .bus    (bus),
        .halted (halted),
        .err    (err)
    );

    mips_multicycle_core #(.MEM_TIMEOUT(8)) dut_to (
        .clk    (clk),
        .rst_b  (rst_b),
        .bus    (bus_to),
        .halted (halted_to),
        .err    (err_to)
    );

    assign bus.imem_ready    = bus.imem_req;
    assign bus.imem_rdata    = rom[bus.imem_addr[8:2]];
    assign bus.dmem_ready    = bus.dmem_req && (dcnt == dlat);
    assign bus.dmem_rdata    = dmem[bus.dmem_addr[7:2]];
    assign bus_to.imem_ready = 1'b0;
    assign bus_to.imem_rdata = 32'd0;
    assign bus_to.dmem_ready = 1'b0;
    assign bus_to.dmem_rdata = 32'd0;

    always @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            dcnt   <= 0;
            n_dreq <= 0;
        end else begin
            dcnt   <= (bus.dmem_req && !bus.dmem_ready) ? dcnt + 1 : 0;
            n_dreq <= bus.dmem_req ? n_dreq + 1 : n_dreq;
        end
    end

    always @(posedge clk) begin
        if (bus.dmem_req && bus.dmem_ready && bus.dmem_we)
            dmem[bus.dmem_addr[7:2]] <= bus.dmem_wdata;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 128; i++) rom[i] = 32'hFC00_0000;
    endtask

    task automatic release_reset();
        rst_b = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_b = 1'b1;
        #1;
    endtask

    task automatic wait_halt(input string tag);
        for (int i = 0; i < 500 && !halted; i++) @(negedge clk);
        check(tag, halted, 1);
    endtask

    initial begin
        int nz;

        // basic ALU program + timeout instance running in parallel
        clear_rom();
        rom[0] = 32'h2001_0005;  // addi $1,$0,5
        rom[1] = 32'h2002_0007;  // addi $2,$0,7
        rom[2] = 32'h0022_1820;  // add  $3,$1,$2
        rom[3] = 32'h0000_000C;  // syscall
        repeat (2) @(posedge clk);
        #1;
        check("rst_halted", halted, 0);
        check("rst_err", err, 0);
        check("rst_imem_req", bus.imem_req, 0);
        check("rst_dmem_req", bus.dmem_req, 0);
        check("rst_dmem_we", bus.dmem_we, 0);
        check("rst_pc", bus.imem_addr, 32'h0);
        release_reset();
        check("c0_imem_req", bus.imem_req, 1);
        check("c0_imem_addr", bus.imem_addr, 32'h0);
        tick(7);
        check("to_c7_req", bus_to.imem_req, 1);
        check("to_c7_halted", halted_to, 0);
        tick(1);
        check("to_c8_req", bus_to.imem_req, 0);
        check("to_c8_halted", halted_to, 1);
        check("to_c8_err", err_to, 1);
        tick(5);
        check("c13_halted", halted, 0);
        tick(1);
        check("c14_halted", halted, 1);
        check("c14_err", err, 0);
        check("c14_imem_req", bus.imem_req, 0);
        check("r3_sum", dut.u_regfile.r_regs[3], 32'd12);

        // ALU ops, $0 write, not-taken beq, sw/lw with 3-cycle data latency
        clear_rom();
        rom[0]  = 32'h2001_0005;  // addi $1,$0,5
        rom[1]  = 32'h2002_0007;  // addi $2,$0,7
        rom[2]  = 32'h0022_1820;  // add  $3,$1,$2
        rom[3]  = 32'h0022_2822;  // sub  $5,$1,$2
        rom[4]  = 32'h0022_3024;  // and  $6,$1,$2
        rom[5]  = 32'h0022_3825;  // or   $7,$1,$2
        rom[6]  = 32'h00A1_402A;  // slt  $8,$5,$1
        rom[7]  = 32'h0025_482A;  // slt  $9,$1,$5
        rom[8]  = 32'h2000_0009;  // addi $0,$0,9
        rom[9]  = 32'h1022_0005;  // beq  $1,$2,+5
        rom[10] = 32'hAC03_0008;  // sw   $3,8($0)
        rom[11] = 32'h8C04_0008;  // lw   $4,8($0)
        rom[12] = 32'h0000_000C;  // syscall
        dlat = 3;
        release_reset();
        for (int i = 0; i < 200 && !bus.dmem_req; i++) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("sw_req_%0d", k), bus.dmem_req, 1);
            check($sformatf("sw_we_%0d", k), bus.dmem_we, 1);
            check($sformatf("sw_addr_%0d", k), bus.dmem_addr, 32'h8);
            check($sformatf("sw_wdata_%0d", k), bus.dmem_wdata, 32'd12);
            check($sformatf("sw_ready_%0d", k), bus.dmem_ready, (k == 3) ? 1 : 0);
            @(negedge clk);
        end
        check("sw_req_dropped", bus.dmem_req, 0);
        wait_halt("alu_halt");
        check("alu_err", err, 0);
        check("r0", dut.u_regfile.r_regs[0], 32'd0);
        check("r4_lw", dut.u_regfile.r_regs[4], 32'd12);
        check("r5_sub", dut.u_regfile.r_regs[5], 32'hFFFF_FFFE);
        check("r6_and", dut.u_regfile.r_regs[6], 32'd5);
        check("r7_or", dut.u_regfile.r_regs[7], 32'd7);
        check("r8_slt", dut.u_regfile.r_regs[8], 32'd1);
        check("r9_slt", dut.u_regfile.r_regs[9], 32'd0);
        check("dmem_word2", dmem[2], 32'd12);

        // jumps and taken beq
        clear_rom();
        rom[0]  = 32'h0800_0040;  // j 0x40
        rom[64] = 32'h0800_0004;  // j 0x4
        rom[4]  = 32'h1021_FFFF;  // beq $1,$1,-1
        release_reset();
        tick(3);
        check("j_0x100", bus.imem_addr, 32'h100);
        check("j_req", bus.imem_req, 1);
        tick(3);
        check("j_0x10", bus.imem_addr, 32'h10);
        tick(3);
        check("beq_self_1", bus.imem_addr, 32'h10);
        tick(3);
        check("beq_self_2", bus.imem_addr, 32'h10);
        check("beq_halted", halted, 0);

        // illegal opcode
        clear_rom();
        rom[0] = 32'hFC00_0000;
        release_reset();
        tick(1);
        check("ill_c1_halted", halted, 0);
        tick(1);
        check("ill_halted", halted, 1);
        check("ill_err", err, 1);
        check("ill_no_dreq", n_dreq, 0);

        // misaligned load
        clear_rom();
        rom[0] = 32'h8C04_0006;   // lw $4,6($0)
        release_reset();
        tick(2);
        check("mis_c2_halted", halted, 0);
        tick(1);
        check("mis_halted", halted, 1);
        check("mis_err", err, 1);
        check("mis_no_dreq", n_dreq, 0);

        // reset during a pending load
        clear_rom();
        rom[0] = 32'h2001_0005;   // addi $1,$0,5
        rom[1] = 32'h8C04_0008;   // lw $4,8($0)
        dlat = 20;
        release_reset();
        for (int i = 0; i < 100 && !bus.dmem_req; i++) @(negedge clk);
        check("pend_req", bus.dmem_req, 1);
        check("pend_r1", dut.u_regfile.r_regs[1], 32'd5);
        rst_b = 1'b0;
        #1;
        check("abort_dmem_req", bus.dmem_req, 0);
        check("abort_imem_req", bus.imem_req, 0);
        nz = 0;
        for (int r = 0; r < 32; r++) if (dut.u_regfile.r_regs[r] != 32'd0) nz++;
        check("abort_regs_zero", nz, 0);
        @(negedge clk);
        rst_b = 1'b1;
        #1;
        check("restart_req", bus.imem_req, 1);
        check("restart_pc", bus.imem_addr, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/mips_multicycle_core.md
MIPS_MULTICYCLE_CORE -- requirements
Module: mips_multicycle_core

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning PC value loaded on reset.
REQ-002 SHALL have parameter MEM_TIMEOUT, default 0, meaning max wait cycles per memory request; 0 disables the timeout.
REQ-003 SHALL have parameter BIG_ENDIAN, default 1, meaning byte 0 of a word is bits [31:24] when 1, [7:0] when 0.
REQ-004 SHALL have port clk  in  1  clock, all state on rising edge.
REQ-005 SHALL have port rst_b  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port imem_req / imem_addr[31:0]  out  1/32  instruction fetch request and word address.
REQ-007 SHALL have port imem_ready / imem_rdata[31:0]  in  1/32  fetch completion and instruction word.
REQ-008 SHALL have port dmem_req / dmem_we / dmem_addr[31:0] / dmem_wdata[31:0]  out  data request, write enable, address, store data.
REQ-009 SHALL have port dmem_ready / dmem_rdata[31:0]  in  1/32  data completion and load data.
REQ-010 SHALL have port halted  out  1  core stopped; port err  out  1  stop caused by fault.

Function
REQ-011 SHALL execute add, sub, and, or, slt (R-type), addi, lw, sw, beq, j, syscall; all other opcode/funct values are illegal.
REQ-012 SHALL sequence FSM states FETCH, DECODE, EXEC, MEM, WB, HALT.
REQ-013 SHALL transition FETCH->DECODE in the cycle imem_ready=1; on that edge IR<=imem_rdata and PC<=PC+4.
REQ-014 SHALL transition DECODE->EXEC normally (regs latch rs/rt into A/B), DECODE->HALT on syscall (err=0), and DECODE->HALT on illegal instruction (err=1).
REQ-015 SHALL transition EXEC->FETCH for beq (PC<=PC+(sext(imm)<<2) when A==B) and j (PC<={PC[31:28],target,2'b00}); EXEC->MEM for lw/sw; EXEC->WB otherwise.
REQ-016 SHALL transition MEM->WB (lw) or MEM->FETCH (sw) in the cycle dmem_ready=1.
REQ-017 SHALL transition WB->FETCH after writing rd (R-type), rt (addi, lw).
REQ-018 SHALL hold req, addr, we, wdata stable while waiting for ready, and drop req in the cycle after ready.
REQ-019 SHALL cost, with zero-wait memory: R-type/addi 4 cycles, lw 5, sw 4, beq/j 3, syscall 2 plus HALT.
REQ-020 SHALL use 32-bit wrap-around arithmetic for add/sub/addi/PC; overflow is ignored; slt is signed.
REQ-021 SHALL read register $0 as 0 and ignore writes to it.
REQ-022 SHALL fault lw/sw with addr[1:0]!=0 in EXEC: no request issued, HALT, err=1.
REQ-023 SHALL, when MEM_TIMEOUT>0 and ready is absent for MEM_TIMEOUT consecutive cycles, drop req and enter HALT with err=1.
REQ-024 SHALL remain in HALT (no requests, no register writes) until reset, with halted=1.
REQ-025 SHALL ignore ready when no request is outstanding.
REQ-026 SHALL apply BIG_ENDIAN byte ordering only to dmem_wdata/dmem_rdata; instructions are always native words.

Reset
REQ-027 SHALL, while rst_b=0, force state=FETCH, PC=RESET_PC, IR=0, all 32 registers=0, req outputs=0, dmem_we=0, halted=0, err=0.
REQ-028 SHALL abort any outstanding request on reset assertion mid-transaction; the first cycle after deassertion issues a fetch at RESET_PC.

Structure
REQ-029 SHALL take opcode/funct constants, state enum, and ALU-op enum from shared package mips_pkg.
REQ-030 SHALL place the register file (2 async read, 1 sync write, async reset) in sub-module mc_regfile.

Verification
REQ-031 SHALL verify zero-wait: addi $1,$0,5; addi $2,$0,7; add $3,$1,$2; syscall -> $3=12, halted at cycle 14, err=0.
REQ-032 SHALL verify: sw $3,8($0) then lw $4,8($0) with 3-cycle dmem latency -> dmem_wdata held 3 cycles, $4=12.
REQ-033 SHALL verify: beq $1,$1,-1 at 0x10 -> next fetch at 0x10; j 0x40 -> next imem_addr=0x100.
REQ-034 SHALL verify: MEM_TIMEOUT=8, imem_ready tied 0 -> req dropped, halted=1, err=1 after 8 cycles.
REQ-035 SHALL verify: illegal opcode 6'h3F and lw at addr 0x6 -> each halts with err=1, no dmem_req.
REQ-036 SHALL verify: rst_b asserted during a pending lw -> dmem_req=0 immediately, next fetch at RESET_PC, registers 0.
